// File: rtl/tl_next_state_timer.sv
// Traffic light next-state logic and dwell timer; drives the external 2-bit
// state register's d inputs and decodes the current state into street lights.
module tl_next_state_timer #(
  parameter int YELLOW_CYCLES    = 5,
  parameter int MIN_GREEN_CYCLES = 10,
  parameter int CNT_W            = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             q1,
  input  logic             q0,
  input  logic             ta,
  input  logic             tb,
  output logic             d1,
  output logic             d0,
  output logic [1:0]       la,
  output logic [1:0]       lb,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    RED    = 2'b10
  } light_e;

  // Thresholds are the last cycle index of each phase, so the counter only
  // needs CNT_W bits even when a phase lasts 2^CNT_W cycles.
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(MIN_GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);

  state_e           w_state;
  state_e           w_next;
  light_e           w_la;
  light_e           w_lb;
  logic             w_green_done;
  logic             w_yellow_done;
  logic [CNT_W-1:0] r_cnt;

  assign w_state       = state_e'({q1, q0});
  assign w_green_done  = (r_cnt >= GREEN_LAST);
  assign w_yellow_done = (r_cnt >= YELLOW_LAST);

  always_comb begin
    w_next = w_state;
    w_la   = RED;
    w_lb   = RED;
    case (w_state)
      S0: begin
        w_la = GREEN;
        if (!ta && w_green_done) w_next = S1;
      end
      S1: begin
        w_la = YELLOW;
        if (w_yellow_done) w_next = S2;
      end
      S2: begin
        w_lb = GREEN;
        if (!tb && w_green_done) w_next = S3;
      end
      S3: begin
        w_lb = YELLOW;
        if (w_yellow_done) w_next = S0;
      end
      default: w_next = S0;
    endcase
    if (!reset_n) w_next = S0;
  end

  // Counter restarts on the edge that commits a state change, so each phase
  // begins counting from zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_next != w_state) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign d1  = w_next[1];
  assign d0  = w_next[0];
  assign la  = w_la;
  assign lb  = w_lb;
  assign cnt = r_cnt;

endmodule

// File: tb/tb_tl_next_state_timer.sv
// Directed bench for tl_next_state_timer: open-loop vector table plus
// closed-loop sequences through a bench-side state register.
module tb_tl_next_state_timer;

  logic       clk;
  logic       reset_n;
  logic       q1, q0;
  logic       ta, tb;
  logic       d1, d0;
  logic [1:0] la, lb;
  logic [7:0] cnt;

  logic       loop_en;
  logic       preset_en;
  logic [1:0] preset_val;
  logic [1:0] q_force;
  logic [1:0] r_q;

  int checks = 0;
  int errors = 0;

  tl_next_state_timer #(
    .YELLOW_CYCLES   (5),
    .MIN_GREEN_CYCLES(10),
    .CNT_W           (8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .q1     (q1),
    .q0     (q0),
    .ta     (ta),
    .tb     (tb),
    .d1     (d1),
    .d0     (d0),
    .la     (la),
    .lb     (lb),
    .cnt    (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream state register, optionally preloaded to start from any state.
  always @(posedge clk) r_q <= preset_en ? preset_val : {d1, d0};

  assign {q1, q0} = loop_en ? r_q : q_force;

  typedef struct {
    logic       rst_n;
    logic [1:0] q;
    logic       ta;
    logic       tb;
    logic [1:0] d;
    logic [1:0] la;
    logic [1:0] lb;
    logic [7:0] cnt_after;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input logic [1:0] exp_q, input logic [7:0] exp_cnt);
    chk({name, "_q"}, {30'd0, q1, q0}, {30'd0, exp_q});
    chk({name, "_cnt"}, {24'd0, cnt}, {24'd0, exp_cnt});
  endtask

  initial begin
    //            rst   q      ta    tb    d      la     lb     cnt
    vecs[0]  = '{1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 8'd0};
    vecs[1]  = '{1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 8'd1};
    vecs[2]  = '{1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 2'b10, 8'd2};
    vecs[3]  = '{1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 8'd3};
    vecs[4]  = '{1'b1, 2'b11, 1'b0, 1'b0, 2'b11, 2'b10, 2'b01, 8'd4};
    vecs[5]  = '{1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 8'd0};
    vecs[6]  = '{1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 2'b10, 8'd1};
    vecs[7]  = '{1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 2'b10, 8'd2};
    vecs[8]  = '{1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 2'b10, 8'd3};
    vecs[9]  = '{1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 2'b10, 8'd4};
    vecs[10] = '{1'b1, 2'b01, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 8'd0};
    vecs[11] = '{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 8'd1};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 8'd0};

    reset_n    = 1'b0;
    ta         = 1'b0;
    tb         = 1'b0;
    q_force    = 2'b00;
    loop_en    = 1'b1;
    preset_en  = 1'b1;
    preset_val = 2'b01;

    // Reset with the register preloaded to S1.
    tick();
    preset_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rst_d", {30'd0, d1, d0}, 32'd0);
      chk_state("rst", (k == 0) ? 2'b01 : 2'b00, 8'd0);
      tick();
    end
    chk_state("rst_end", 2'b00, 8'd0);

    // Open-loop vector table.
    loop_en = 1'b0;
    for (int i = 0; i < 13; i++) begin
      reset_n = vecs[i].rst_n;
      q_force = vecs[i].q;
      ta      = vecs[i].ta;
      tb      = vecs[i].tb;
      #1;
      chk($sformatf("vec%0d_d", i), {30'd0, d1, d0}, {30'd0, vecs[i].d});
      chk($sformatf("vec%0d_la", i), {30'd0, la}, {30'd0, vecs[i].la});
      chk($sformatf("vec%0d_lb", i), {30'd0, lb}, {30'd0, vecs[i].lb});
      tick();
      chk($sformatf("vec%0d_cnt", i), {24'd0, cnt}, {24'd0, vecs[i].cnt_after});
    end

    // Closed loop from reset: S0 10 cycles, S1 5 cycles, S2 held while tb=1.
    loop_en = 1'b1;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    ta      = 1'b0;
    tb      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk_state("s0_phase", 2'b00, 8'(i));
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_state("s1_phase", 2'b01, 8'(i));
      tick();
    end
    for (int i = 0; i < 15; i++) begin
      #1;
      chk_state("s2_hold", 2'b10, 8'(i));
      if (i == 14) tb = 1'b0;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_state("s3_phase", 2'b11, 8'(i));
      tick();
    end

    // S0: a sensor drop before minimum green, gone again when cnt qualifies.
    for (int i = 0; i < 21; i++) begin
      if (i == 0) ta = 1'b1;
      if (i == 4) ta = 1'b0;
      if (i == 8) ta = 1'b1;
      #1;
      chk_state("s0_early_drop", 2'b00, 8'(i));
      chk("s0_early_drop_d", {30'd0, d1, d0}, 32'd0);
      tick();
    end

    // Saturation with persistent traffic, then release.
    for (int i = 0; i < 300; i++) tick();
    chk_state("sat", 2'b00, 8'd255);
    tick();
    chk_state("sat_hold", 2'b00, 8'd255);
    ta = 1'b0;
    #1;
    chk("sat_release_d", {30'd0, d1, d0}, 32'd1);
    tick();
    chk_state("sat_to_s1", 2'b01, 8'd0);

    // Reset pulse mid-yellow.
    tick();
    tick();
    chk_state("s1_pre_rst", 2'b01, 8'd2);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_d", {30'd0, d1, d0}, 32'd0);
    tick();
    chk_state("mid_rst", 2'b00, 8'd0);
    reset_n = 1'b1;
    tb      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk_state("post_rst_s0", 2'b00, 8'(i));
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_state("post_rst_s1", 2'b01, 8'(i));
      tick();
    end

    // S2 with tb dropped at cnt=3: full minimum green still applies.
    for (int i = 0; i < 10; i++) begin
      if (i == 3) tb = 1'b0;
      #1;
      chk_state("s2_min", 2'b10, 8'(i));
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_state("s3_after_min", 2'b11, 8'(i));
      tick();
    end
    #1;
    chk_state("back_to_s0", 2'b00, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_next_state_timer.md
# tl_next_state_timer

Next-state and dwell-timing stage of the traffic light controller. It sits directly upstream of the 2-bit state register: it reads the current state (`q1`, `q0`) and the street sensors, and drives the register's `d1`/`d0` inputs. An internal dwell counter enforces a minimum green time and a fixed yellow time. It also decodes the current state into light outputs for both streets.

## Interface
- `YELLOW_CYCLES`, default 5: cycles spent in each yellow state; legal range 1..2^CNT_W.
- `MIN_GREEN_CYCLES`, default 10: minimum cycles in each green state before it may be left; legal range 1..2^CNT_W.
- `CNT_W`, default 8: dwell counter width.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset_n` input 1: reset, synchronous and active-low (sampled on the `clk` rising edge).
- `q1`, `q0` input 1 each: current state from the state register.
- `ta` input 1: traffic present on street A.
- `tb` input 1: traffic present on street B.
- `d1`, `d0` output 1 each: next state, wired to the state register's `d1`/`d0`.
- `la` output 2: street A light.
- `lb` output 2: street B light.
- `cnt` output CNT_W: dwell counter, exposed for debug and verification.

## Operation
- State encoding on {q1,q0}:
  - S0=00: A green, B red.
  - S1=01: A yellow, B red.
  - S2=10: A red, B green.
  - S3=11: A red, B yellow.
- Light encoding: 00 green, 01 yellow, 10 red. 11 is never driven.
- `la`/`lb` are a pure combinational decode of {q1,q0}.
- Next state {d1,d0} is combinational from q, ta, tb, cnt and reset_n:
  - S0 goes to S1 when `ta`=0 and `cnt` >= MIN_GREEN_CYCLES-1; otherwise it stays S0.
  - S1 goes to S2 when `cnt` >= YELLOW_CYCLES-1; otherwise it stays S1.
  - S2 goes to S3 when `tb`=0 and `cnt` >= MIN_GREEN_CYCLES-1; otherwise it stays S2.
  - S3 goes to S0 when `cnt` >= YELLOW_CYCLES-1; otherwise it stays S3.
  - While `reset_n`=0, {d1,d0} is forced to 00 regardless of q.
- Dwell counter, updated on each clock edge (first matching rule applies):
  - `reset_n`=0: `cnt` loads 0.
  - Else {d1,d0} != {q1,q0} (a transition is being committed): `cnt` loads 0.
  - Else `cnt` increments by 1, saturating at 2^CNT_W-1. It never wraps.
- Sensors are evaluated every cycle. Only their value in the cycle where `cnt` qualifies matters, so a sensor drop before the minimum green time causes nothing.
- All four encodings are legal. There is no illegal-state recovery.

## Timing
- Reset values: `cnt`=0 and {d1,d0}=00 while `reset_n`=0. `la`=00 and `lb`=10 whenever q=00.
- {d1,d0} has zero latency from q, ta, tb and cnt. There is one cycle of latency through the downstream register.
- With the state register in the loop:
  - Each yellow state lasts exactly YELLOW_CYCLES cycles.
  - Each green state lasts at least MIN_GREEN_CYCLES cycles, and continues until the street's sensor is 0 in a qualifying cycle.
- First S0 after reset release: `cnt` starts at 0, so the full minimum green applies.
- Reset asserted mid-phase: at the next edge `cnt`=0 and the register loads 00. Whatever remained of the current phase is discarded.
- Sensor and counter qualify in the same cycle: the transition is committed at that edge. Sensor changes after that edge are ignored until the next green.
- Counter saturation: with persistent traffic, `cnt` holds at 2^CNT_W-1, and the green state releases on the first cycle its sensor is 0.

## Test plan
- Reset with q forced to 01 and `reset_n`=0 for 3 cycles: `d1`/`d0`=00 each cycle, `cnt`=0, and q=00 after the first edge.
- Loop closed, defaults, `ta`=0, `tb`=1 from reset release: S0 for 10 cycles, S1 for 5 cycles, then S2 held while `tb`=1.
- From S2 entry with `tb` dropped at `cnt`=3: S2 held until `cnt`=9 (10 cycles total), then S3 for 5 cycles, then S0 with `cnt`=0.
- In S0, `ta`=0 at `cnt`=4, then `ta`=1 from `cnt`=8 onward: no transition, `d1`/`d0` stays 00.
- In S0 with `ta`=1 for 300 cycles: `cnt` saturates at 255 and holds. Dropping `ta` then gives S1 at the next edge.
- `reset_n` pulsed low for 1 cycle in S1 at `cnt`=2: q=00 and `cnt`=0 next edge. After release, S0 holds 10 cycles before S1.
